// File: rtl/int_priority_controller_if.sv
// ---------------------------------------------------------------------------
// int_priority_controller_if
// Purpose : bundles the request, IACK and config-strobe signals that flow
//           between the bus decoder / request sources (master side) and the
//           68000 interrupt priority controller (slave side).
// Signals :
//   INT_REQ_IN    [6:0] bit i = request for IPL level i+1
//   IACK_IN             high while the MPU runs an IACK cycle
//   IACK_LEVEL_IN [2:0] level being acknowledged (A3..A1)
//   CFG_WR_IN           one-cycle config write strobe
//   CFG_SEL_IN          0 = enable mask write, 1 = pending write-1-to-clear
//   CFG_DATA_IN   [6:0] config write data, bit i = level i+1
//   INT_LEVEL     [2:0] encoded IPL to the MPU, 0 = none
//   AVEC_ACK            autovector acknowledge
//   SPURIOUS_ACK        BERR request for an unmatched IACK
//   ENABLE_OUT    [6:0] current enable mask
//   PENDING_OUT   [6:0] latched pending (edge bits) / raw request (level bits)
// ---------------------------------------------------------------------------
interface int_priority_controller_if;
  logic [6:0] INT_REQ_IN;
  logic       IACK_IN;
  logic [2:0] IACK_LEVEL_IN;
  logic       CFG_WR_IN;
  logic       CFG_SEL_IN;
  logic [6:0] CFG_DATA_IN;
  logic [2:0] INT_LEVEL;
  logic       AVEC_ACK;
  logic       SPURIOUS_ACK;
  logic [6:0] ENABLE_OUT;
  logic [6:0] PENDING_OUT;

  // Bus decoder and request sources drive the inputs and observe the outputs.
  modport master (
    output INT_REQ_IN, IACK_IN, IACK_LEVEL_IN, CFG_WR_IN, CFG_SEL_IN, CFG_DATA_IN,
    input  INT_LEVEL, AVEC_ACK, SPURIOUS_ACK, ENABLE_OUT, PENDING_OUT
  );

  // The controller itself.
  modport slave (
    input  INT_REQ_IN, IACK_IN, IACK_LEVEL_IN, CFG_WR_IN, CFG_SEL_IN, CFG_DATA_IN,
    output INT_LEVEL, AVEC_ACK, SPURIOUS_ACK, ENABLE_OUT, PENDING_OUT
  );
endinterface

// File: rtl/int_priority_controller.sv
// ---------------------------------------------------------------------------
// int_priority_controller
// Purpose : owns the 68000 interrupt path. Collects seven requests (one per
//           IPL level), latches edge-type requests, gates them with a
//           software enable mask, drives the encoded IPL and sequences the
//           interrupt-acknowledge cycle with an autovector or spurious reply.
// Ports   :
//   CPUCLK_IN  block clock, all state updates on its rising edge
//   RESET_IN   synchronous active-high reset
//   bus        int_priority_controller_if.slave (requests, IACK, config
//              strobes in; IPL, acknowledges, enable and pending state out)
// Parameters:
//   EDGE_MASK    bit i = 1 makes level i+1 rising-edge latched
//   ENABLE_RESET reset value of the enable mask
// ---------------------------------------------------------------------------
module int_priority_controller #(
  parameter logic [6:0] EDGE_MASK    = 7'b0000001,
  parameter logic [6:0] ENABLE_RESET = 7'b0000000
) (
  input  logic                        CPUCLK_IN,
  input  logic                        RESET_IN,
  int_priority_controller_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_SPUR = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic [1:0] r_state;
  logic [6:0] r_reqPrev;
  logic [6:0] r_pending;
  logic [6:0] r_enable;
  logic [2:0] r_intLevel;
  logic       r_avecAck;
  logic       r_spurAck;

  logic [6:0] w_rise;
  logic [6:0] w_effReq;
  logic [6:0] w_active;
  logic [2:0] w_encLevel;
  logic [7:0] w_levelOneHot;
  logic       w_accept;
  logic [6:0] w_clear;

  // Edge bits come from the pending latch, level bits straight from the pins.
  assign w_rise   = bus.INT_REQ_IN & ~r_reqPrev & EDGE_MASK;
  assign w_effReq = (r_pending & EDGE_MASK) | (bus.INT_REQ_IN & ~EDGE_MASK);
  assign w_active = w_effReq & r_enable;

  // Bit 0 of the one-hot stands for level 0, which never matches a source,
  // so an IACK for level 0 falls through to the spurious path.
  assign w_levelOneHot = 8'd1 << bus.IACK_LEVEL_IN;
  assign w_accept      = (r_state == ST_IDLE) && bus.IACK_IN &&
                         (|(w_levelOneHot[7:1] & w_active));

  // Pending bits cleared this cycle: W1C config write plus the accepted level.
  assign w_clear = ((bus.CFG_WR_IN && bus.CFG_SEL_IN) ? bus.CFG_DATA_IN : 7'd0) |
                   (w_accept ? w_levelOneHot[7:1] : 7'd0);

  // Priority encoder: the highest active level wins.
  always_comb begin
    w_encLevel = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (w_active[i]) w_encLevel = 3'(i + 1);
    end
  end

  // Edge history, pending latch and enable mask. A rising edge in the same
  // cycle as a clear keeps the bit set.
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_reqPrev <= 7'd0;
      r_pending <= 7'd0;
      r_enable  <= ENABLE_RESET;
    end else begin
      r_reqPrev <= bus.INT_REQ_IN;
      r_pending <= ((r_pending & ~w_clear) | w_rise) & EDGE_MASK;
      if (bus.CFG_WR_IN && !bus.CFG_SEL_IN) r_enable <= bus.CFG_DATA_IN;
    end
  end

  // IPL output; held steady while an acknowledge is in progress so the MPU
  // sees a stable level for the whole IACK cycle.
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_intLevel <= 3'd0;
    end else if (r_state != ST_ACK && r_state != ST_SPUR) begin
      r_intLevel <= w_encLevel;
    end
  end

  // IACK sequencer. The decision is taken once on entry from IDLE; WAIT
  // enforces an idle cycle between acknowledges.
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_state   <= ST_IDLE;
      r_avecAck <= 1'b0;
      r_spurAck <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.IACK_IN) begin
            if (w_accept) begin
              r_state   <= ST_ACK;
              r_avecAck <= 1'b1;
            end else begin
              r_state   <= ST_SPUR;
              r_spurAck <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (!bus.IACK_IN) begin
            r_state   <= ST_WAIT;
            r_avecAck <= 1'b0;
          end
        end
        ST_SPUR: begin
          if (!bus.IACK_IN) begin
            r_state   <= ST_WAIT;
            r_spurAck <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_avecAck <= 1'b0;
          r_spurAck <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INT_LEVEL    = r_intLevel;
  assign bus.AVEC_ACK     = r_avecAck;
  assign bus.SPURIOUS_ACK = r_spurAck;
  assign bus.ENABLE_OUT   = r_enable;
  assign bus.PENDING_OUT  = w_effReq;

endmodule

// File: tb/tb_int_priority_controller.sv
// ---------------------------------------------------------------------------
// tb_int_priority_controller
// Purpose : drives the interrupt priority controller with the directed
//           scenarios followed by random traffic, predicting every cycle's
//           outputs with a behavioural model and checking them in a separate
//           monitor process.
// ---------------------------------------------------------------------------
module tb_int_priority_controller;

  localparam logic [6:0] EDGE_MASK    = 7'b0000001;
  localparam logic [6:0] ENABLE_RESET = 7'b0000000;

  typedef struct {
    logic [2:0] lvl;
    logic       avec;
    logic       spur;
    logic [6:0] en;
    logic [6:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  // Behavioural model state: phase 0 idle, 1 autovector held, 2 spurious held,
  // 3 mandatory gap cycle.
  logic [6:0] mPrev, mPend, mEn;
  logic [2:0] mLvl;
  logic       mAvec, mSpur;
  int         mPhase;

  always #5 clk = ~clk;

  int_priority_controller_if bus();

  int_priority_controller #(
    .EDGE_MASK   (EDGE_MASK),
    .ENABLE_RESET(ENABLE_RESET)
  ) dut (
    .CPUCLK_IN(clk),
    .RESET_IN (rst),
    .bus      (bus)
  );

  // Highest set bit, searched from the top, as an IPL number.
  function automatic logic [2:0] highestLevel(input logic [6:0] v);
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) return 3'(i + 1);
    end
    return 3'd0;
  endfunction

  // One clock edge of the reference model, reading the inputs the DUT sees.
  task automatic modelStep();
    logic [6:0] eff, act, newPend, req;
    int         lv;
    bit         hit;
    req = bus.INT_REQ_IN;
    lv  = int'(bus.IACK_LEVEL_IN);
    if (rst) begin
      mPrev = 7'd0; mPend = 7'd0; mEn = ENABLE_RESET;
      mLvl = 3'd0; mAvec = 1'b0; mSpur = 1'b0; mPhase = 0;
    end else begin
      eff = (mPend & EDGE_MASK) | (req & ~EDGE_MASK);
      act = eff & mEn;
      hit = (lv != 0) && act[lv-1];
      if (mPhase != 1 && mPhase != 2) mLvl = highestLevel(act);
      newPend = mPend;
      if (bus.CFG_WR_IN && bus.CFG_SEL_IN) newPend = newPend & ~bus.CFG_DATA_IN;
      if (mPhase == 0 && bus.IACK_IN && hit) newPend[lv-1] = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (EDGE_MASK[i] && req[i] && !mPrev[i]) newPend[i] = 1'b1;
      end
      mPend = newPend & EDGE_MASK;
      case (mPhase)
        0: if (bus.IACK_IN) begin
             if (hit) begin mPhase = 1; mAvec = 1'b1; end
             else     begin mPhase = 2; mSpur = 1'b1; end
           end
        1, 2: if (!bus.IACK_IN) begin mPhase = 3; mAvec = 1'b0; mSpur = 1'b0; end
        default: mPhase = 0;
      endcase
      if (bus.CFG_WR_IN && !bus.CFG_SEL_IN) mEn = bus.CFG_DATA_IN;
      mPrev = req;
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the model predict the post-edge outputs,
  // and queue the prediction for the monitor.
  task automatic applyStimulus(input logic r, input logic [6:0] req, input logic iack,
                               input logic [2:0] lvl, input logic wr, input logic sel,
                               input logic [6:0] data);
    exp_t e;
    rst               = r;
    bus.INT_REQ_IN    = req;
    bus.IACK_IN       = iack;
    bus.IACK_LEVEL_IN = lvl;
    bus.CFG_WR_IN     = wr;
    bus.CFG_SEL_IN    = sel;
    bus.CFG_DATA_IN   = data;
    @(posedge clk);
    modelStep();
    e.lvl  = mLvl;
    e.avec = mAvec;
    e.spur = mSpur;
    e.en   = mEn;
    e.pend = (mPend & EDGE_MASK) | (req & ~EDGE_MASK);
    expQ.push_back(e);
    #2;
  endtask

  // Monitor: every cycle with a prediction outstanding, compare the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("INT_LEVEL",    7'(bus.INT_LEVEL),    7'(e.lvl));
        checkOutput("AVEC_ACK",     7'(bus.AVEC_ACK),     7'(e.avec));
        checkOutput("SPURIOUS_ACK", 7'(bus.SPURIOUS_ACK), 7'(e.spur));
        checkOutput("ENABLE_OUT",   bus.ENABLE_OUT,       e.en);
        checkOutput("PENDING_OUT",  bus.PENDING_OUT,      e.pend);
        checkOutput("ACK_EXCLUSIVE", 7'(bus.AVEC_ACK & bus.SPURIOUS_ACK), 7'd0);
      end
    end
  end

  initial begin
    int         iackLeft;
    logic [2:0] iackLvl;
    logic [6:0] req;
    logic       wr;
    logic       doRst;

    // Reset state.
    applyStimulus(1, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(1, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("rst_level",  7'(bus.INT_LEVEL), 7'd0);
    checkOutput("rst_avec",   7'(bus.AVEC_ACK), 7'd0);
    checkOutput("rst_spur",   7'(bus.SPURIOUS_ACK), 7'd0);
    checkOutput("rst_enable", bus.ENABLE_OUT, ENABLE_RESET);

    // Timer edge acknowledged by autovector.
    applyStimulus(0, 7'h00, 0, 3'd0, 1, 0, 7'h7F);
    applyStimulus(0, 7'h01, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("edge_level", 7'(bus.INT_LEVEL), 7'd1);
    applyStimulus(0, 7'h00, 1, 3'd1, 0, 0, 7'h00);
    checkOutput("ack_avec",    7'(bus.AVEC_ACK), 7'd1);
    checkOutput("ack_pending", 7'(bus.PENDING_OUT[0]), 7'd0);
    applyStimulus(0, 7'h00, 1, 3'd1, 0, 0, 7'h00);
    checkOutput("ack_hold", 7'(bus.AVEC_ACK), 7'd1);
    applyStimulus(0, 7'h00, 0, 3'd1, 0, 0, 7'h00);
    checkOutput("ack_drop", 7'(bus.AVEC_ACK), 7'd0);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("post_wait_level", 7'(bus.INT_LEVEL), 7'd0);

    // Level-sensitive sources and mask rewrite.
    applyStimulus(0, 7'h06, 0, 3'd0, 1, 0, 7'h06);
    applyStimulus(0, 7'h06, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("level_3", 7'(bus.INT_LEVEL), 7'd3);
    applyStimulus(0, 7'h06, 0, 3'd0, 1, 0, 7'h02);
    applyStimulus(0, 7'h06, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("level_2", 7'(bus.INT_LEVEL), 7'd2);

    // Spurious IACK, then a real one proving the sequencer is back in IDLE.
    applyStimulus(0, 7'h06, 1, 3'd5, 0, 0, 7'h00);
    checkOutput("spur_set",  7'(bus.SPURIOUS_ACK), 7'd1);
    checkOutput("spur_avec", 7'(bus.AVEC_ACK), 7'd0);
    applyStimulus(0, 7'h06, 0, 3'd5, 0, 0, 7'h00);
    checkOutput("spur_drop", 7'(bus.SPURIOUS_ACK), 7'd0);
    applyStimulus(0, 7'h06, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h06, 1, 3'd2, 0, 0, 7'h00);
    checkOutput("after_spur_avec", 7'(bus.AVEC_ACK), 7'd1);
    applyStimulus(0, 7'h06, 0, 3'd2, 0, 0, 7'h00);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);

    // Masked edge stays pending, shows once enabled, W1C removes it.
    applyStimulus(0, 7'h00, 0, 3'd0, 1, 0, 7'h00);
    applyStimulus(0, 7'h01, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("masked_level", 7'(bus.INT_LEVEL), 7'd0);
    checkOutput("masked_pend",  7'(bus.PENDING_OUT[0]), 7'd1);
    applyStimulus(0, 7'h00, 0, 3'd0, 1, 0, 7'h01);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("unmask_level", 7'(bus.INT_LEVEL), 7'd1);
    applyStimulus(0, 7'h00, 0, 3'd0, 1, 1, 7'h01);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    checkOutput("w1c_level", 7'(bus.INT_LEVEL), 7'd0);

    // Edge and W1C in the same cycle: the set wins.
    applyStimulus(0, 7'h01, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    applyStimulus(0, 7'h01, 0, 3'd0, 1, 1, 7'h01);
    checkOutput("set_wins", 7'(bus.PENDING_OUT[0]), 7'd1);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);

    // Reset in the middle of an acknowledge.
    applyStimulus(0, 7'h00, 1, 3'd1, 0, 0, 7'h00);
    checkOutput("pre_rst_avec", 7'(bus.AVEC_ACK), 7'd1);
    applyStimulus(1, 7'h00, 1, 3'd1, 0, 0, 7'h00);
    checkOutput("mid_rst_avec",   7'(bus.AVEC_ACK), 7'd0);
    checkOutput("mid_rst_level",  7'(bus.INT_LEVEL), 7'd0);
    checkOutput("mid_rst_enable", bus.ENABLE_OUT, ENABLE_RESET);
    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);

    // Random traffic against the model.
    iackLeft = 0;
    iackLvl  = 3'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req   = 7'($urandom) & 7'($urandom);
      wr    = ($urandom_range(0, 7) == 0);
      doRst = ($urandom_range(0, 299) == 0);
      if (iackLeft > 0) begin
        iackLeft--;
        if ($urandom_range(0, 7) == 0) iackLvl = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 5) == 0) begin
        iackLeft = $urandom_range(1, 4);
        iackLvl  = 3'($urandom_range(0, 7));
      end
      applyStimulus(doRst, req, (iackLeft > 0), iackLvl, wr,
                    1'($urandom_range(0, 1)), 7'($urandom));
    end

    applyStimulus(0, 7'h00, 0, 3'd0, 0, 0, 7'h00);
    #20;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_priority_controller.md
Name: int_priority_controller

Overview:
- Owns the 68000 interrupt path: collects requests from up to seven sources (timer, UART send, UART receive, reserved), one source per IPL level.
- Latches edge-type requests and gates each source by a software enable mask.
- Drives the encoded IPL to the MPU and sequences the interrupt-acknowledge cycle, answering with an autovector acknowledge or a spurious (bus-error) request.
- Sits beside the bus decoder, which forwards IACK cycles and the config-register strobes to this block.

Parameters:
- EDGE_MASK, 7'b0000001: bit i=1 makes level i+1 edge-triggered (rising edge latched); 0 makes it level-sensitive.
- ENABLE_RESET, 7'b0000000: reset value of the enable mask.

Ports:
- CPUCLK_IN  in  1  block clock; all state updates on its rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- INT_REQ_IN  in  7  bit i = request for level i+1; synchronous to CPUCLK_IN.
- IACK_IN  in  1  high while the MPU runs an IACK cycle (AS, both strobes, FC=111).
- IACK_LEVEL_IN  in  3  level being acknowledged (A3..A1); valid while IACK_IN is high.
- CFG_WR_IN  in  1  one-cycle config write strobe.
- CFG_SEL_IN  in  1  0 = enable mask write; 1 = pending write-1-to-clear.
- CFG_DATA_IN  in  7  write data, bit i = level i+1.
- INT_LEVEL  out  3  encoded IPL to the MPU, 0 = none; registered.
- AVEC_ACK  out  1  autovector acknowledge; registered.
- SPURIOUS_ACK  out  1  requests BERR for an unmatched IACK; registered.
- ENABLE_OUT  out  7  current enable mask.
- PENDING_OUT  out  7  edge bits show the latched pending state; level bits show raw INT_REQ_IN.

Behaviour:
- Reset (RESET_IN high at a clock edge):
  - INT_LEVEL=0, AVEC_ACK=0, SPURIOUS_ACK=0.
  - Edge pending=0, edge-detect history=0, ENABLE_OUT=ENABLE_RESET, state=IDLE.
  - Reset wins over every other event, including in the middle of an acknowledge; AVEC_ACK and SPURIOUS_ACK drop at that edge.
- Edge sources:
  - A rising edge means INT_REQ_IN[i]=1 with the previous-cycle sample 0.
  - A rising edge sets pending[i] whether or not the level is enabled.
  - The pending bit clears on an accepted IACK for its level, or on a W1C write with that bit set.
  - If a rising edge and a clear hit the same cycle, set wins.
- Level sources: effective request = INT_REQ_IN[i]; nothing is latched.
- Active vector: active = effective request AND ENABLE_OUT.
- INT_LEVEL:
  - Registered; equals the index+1 of the highest set bit of active, or 0 if none.
  - Latency is 1 cycle from an input/enable change to INT_LEVEL.
  - An edge request shows on INT_LEVEL 2 cycles after the rising edge: detect, then encode.
  - INT_LEVEL is frozen while the state is ACK or SPUR.
- Config writes:
  - CFG_SEL_IN=0 loads ENABLE_OUT <= CFG_DATA_IN.
  - CFG_SEL_IN=1 clears the pending bits where CFG_DATA_IN=1; level bits are ignored.
  - Writes take effect 1 cycle later and are accepted in any state.
- State machine (IDLE, ACK, SPUR, WAIT):
  - IDLE, IACK_IN=1 and active[IACK_LEVEL_IN-1]=1 (level != 0):
    - Go to ACK and set AVEC_ACK=1 on the same edge.
    - Clear the edge pending bit of that level on that edge.
  - IDLE, IACK_IN=1 otherwise (level 0, not pending, or masked): go to SPUR and set SPURIOUS_ACK=1.
  - ACK / SPUR:
    - Hold the acknowledge output while IACK_IN=1.
    - When IACK_IN=0, drop the output at that edge and go to WAIT.
  - WAIT: one cycle, then IDLE. A new IACK is not evaluated in WAIT, which guarantees one idle cycle between acknowledges.
  - IACK_LEVEL_IN changing mid-cycle is ignored; the decision is made only on entry.
  - AVEC_ACK and SPURIOUS_ACK are never both 1.
- After the ack, INT_LEVEL re-encodes from the updated active vector in the cycle after WAIT.

Test Plan:
- Reset, enable=7'h7F, pulse INT_REQ_IN[0] for 1 cycle:
  - INT_LEVEL=1 two cycles later.
  - IACK level 1 -> AVEC_ACK=1 until IACK_IN falls, PENDING_OUT[0]=0.
  - INT_LEVEL=0 after WAIT.
- Levels 2 and 3 high (level-sensitive), enable=7'h06 -> INT_LEVEL=3.
  - Mask write 7'h02 -> INT_LEVEL=2 one cycle after the write.
- IACK level 5 with nothing pending -> SPURIOUS_ACK=1, AVEC_ACK stays 0, state returns to IDLE after IACK_IN falls.
- Enable=0, pulse INT_REQ_IN[0] -> INT_LEVEL stays 0 and PENDING_OUT[0]=1.
  - Enable bit 0 -> INT_LEVEL=1.
  - W1C 7'h01 -> INT_LEVEL=0.
- Timer edge in the same cycle as the W1C of bit 0 -> PENDING_OUT[0] remains 1.
- RESET_IN asserted during ACK with AVEC_ACK=1 -> AVEC_ACK=0, INT_LEVEL=0 and ENABLE_OUT=ENABLE_RESET next edge, even with IACK_IN still high.
